serial_collect: RTL and testbench

SERIAL_COLLECT -- requirements
Module: serial_collect

---
 rtl/serial_collect_pkg.sv | 20 ++
 rtl/serial_collect.sv | 101 ++++++++++
 tb/tb_serial_collect.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_collect_pkg.sv
// Shared constants and types for the LSB-first serial word collector.
package serial_collect_pkg;

  // Default serial word width in bits.
  localparam int W_DEF = 8;

  // Bit-counter width for a word of w bits: ceil(log2(w)), never below 1.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W_DEF = cnt_width(W_DEF);

  // Collector phase, decoded from the bit counter (IDLE when cnt == 0).
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } st_e;

endpackage

// File: rtl/serial_collect.sv
// Serial-to-parallel collector: gathers W valid bits (LSB first) into one
// word held in a single-entry output register with a valid/ready handshake.
module serial_collect
  import serial_collect_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         t_clk,
  input  logic         r,
  input  logic         i,
  input  logic         i_vld,
  input  logic         i_sof,
  output logic [W-1:0] o_word,
  output logic         o_vld,
  input  logic         o_rdy,
  output logic         o_frm_err,
  output logic         o_ovf
);

  localparam int            CW   = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [W-1:0]  word_q, word_d;
  logic          vld_q, vld_d;
  logic          ferr_q, ferr_d;
  logic          ovf_q, ovf_d;
  logic          done;
  st_e           st;

  assign st = (cnt_q == '0) ? ST_IDLE : ST_COLLECT;

  // Next state: bit capture, resync on i_sof, completion and output handshake.
  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    word_d = word_q;
    vld_d  = vld_q;
    ferr_d = 1'b0;
    ovf_d  = ovf_q;
    done   = 1'b0;

    // Downstream consumes the held word.
    if (vld_q && o_rdy) vld_d = 1'b0;

    if (i_vld) begin
      if (i_sof) begin
        // Resync: drop any partial word; flag it only if one was in progress.
        ferr_d  = (st == ST_COLLECT);
        sh_d    = '0;
        sh_d[0] = i;
        cnt_d   = CW'(1);
      end else begin
        sh_d[cnt_q] = i;
        if (cnt_q == LAST) begin
          done  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    // A finished word loads if the slot is free or being freed this edge;
    // otherwise it is lost and the overflow flag sticks.
    if (done) begin
      if (!vld_q || o_rdy) begin
        word_d = sh_d;
        vld_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset taking priority over all inputs.
  always_ff @(posedge t_clk) begin
    if (r) begin
      cnt_q  <= '0;
      sh_q   <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      word_q <= word_d;
      vld_q  <= vld_d;
      ferr_q <= ferr_d;
      ovf_q  <= ovf_d;
    end
  end

  assign o_word    = word_q;
  assign o_vld     = vld_q;
  assign o_frm_err = ferr_q;
  assign o_ovf     = ovf_q;

endmodule

// File: tb/tb_serial_collect.sv
// Self-checking bench for serial_collect (W=8): table-driven words plus
// hand-written resync / overflow / handshake / reset sequences, with a
// scoreboard queue of words expected to be consumed downstream.
module tb_serial_collect;

  localparam int W = 8;

  logic         t_clk = 1'b0;
  logic         r     = 1'b1;
  logic         i     = 1'b0;
  logic         i_vld = 1'b0;
  logic         i_sof = 1'b0;
  logic         o_rdy = 1'b1;
  logic [W-1:0] o_word;
  logic         o_vld;
  logic         o_frm_err;
  logic         o_ovf;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb_q[$];

  serial_collect #(.W(W)) dut (
    .t_clk     (t_clk),
    .r         (r),
    .i         (i),
    .i_vld     (i_vld),
    .i_sof     (i_sof),
    .o_word    (o_word),
    .o_vld     (o_vld),
    .o_rdy     (o_rdy),
    .o_frm_err (o_frm_err),
    .o_ovf     (o_ovf)
  );

  always #5 t_clk = ~t_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: a word is consumed at the next edge when o_vld && o_rdy.
  always @(negedge t_clk) begin
    if (!r && o_vld === 1'b1 && o_rdy === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_word", {24'h0, o_word}, 32'hdead);
      end else begin
        logic [W-1:0] e;
        e = sb_q.pop_front();
        chk("sb_word", {24'h0, o_word}, {24'h0, e});
      end
    end
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge t_clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input logic sof);
    i = b; i_vld = 1'b1; i_sof = sof;
    tick();
    i_vld = 1'b0; i_sof = 1'b0; i = 1'b0;
  endtask

  // Send bits lo..hi of w; optional i_sof on bit 0; idle gaps between bits.
  task automatic send_bits(input logic [W-1:0] w, input int lo, input int hi,
                           input logic sof_first, input int gaps);
    for (int k = lo; k <= hi; k++) begin
      drive_bit(w[k], sof_first && (k == 0));
      if (k != W - 1) repeat (gaps) tick();
    end
  endtask

  task automatic do_reset();
    r = 1'b1;
    tick();
    r = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] word;
    logic         sof;
    int           gaps;
    logic [W-1:0] exp_word;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic ferr_seen;

    vecs[0] = '{8'h5A, 1'b1, 0, 8'h5A};
    vecs[1] = '{8'h5A, 1'b1, 2, 8'h5A};
    vecs[2] = '{8'hA5, 1'b0, 0, 8'hA5};
    vecs[3] = '{8'h00, 1'b1, 1, 8'h00};
    vecs[4] = '{8'hFF, 1'b0, 3, 8'hFF};
    vecs[5] = '{8'h81, 1'b1, 0, 8'h81};

    // Reset state.
    tick(); tick();
    chk("rst_word", {24'h0, o_word}, 32'h0);
    chk("rst_vld",  {31'h0, o_vld}, 32'h0);
    chk("rst_ferr", {31'h0, o_frm_err}, 32'h0);
    chk("rst_ovf",  {31'h0, o_ovf}, 32'h0);
    r = 1'b0;

    // Table: single words with o_rdy=1, with and without sof / gaps.
    o_rdy = 1'b1;
    foreach (vecs[n]) begin
      sb_q.push_back(vecs[n].exp_word);
      send_bits(vecs[n].word, 0, 0, vecs[n].sof, 0);
      chk($sformatf("tbl%0d_sof_idle_ferr", n), {31'h0, o_frm_err}, 32'h0);
      repeat (vecs[n].gaps) tick();
      send_bits(vecs[n].word, 1, W - 2, 1'b0, vecs[n].gaps);
      chk($sformatf("tbl%0d_vld_early", n), {31'h0, o_vld}, 32'h0);
      send_bits(vecs[n].word, W - 1, W - 1, 1'b0, 0);
      chk($sformatf("tbl%0d_vld", n), {31'h0, o_vld}, 32'h1);
      chk($sformatf("tbl%0d_word", n), {24'h0, o_word}, {24'h0, vecs[n].exp_word});
      tick();
      chk($sformatf("tbl%0d_vld_clr", n), {31'h0, o_vld}, 32'h0);
    end

    // Resync: 3 partial bits, then sof starts 0xC3.
    sb_q.push_back(8'hC3);
    send_bits(8'h07, 0, 2, 1'b1, 0);
    drive_bit(1'b1, 1'b1);
    chk("resync_ferr_pulse", {31'h0, o_frm_err}, 32'h1);
    ferr_seen = 1'b0;
    for (int k = 1; k < W; k++) begin
      drive_bit(((8'hC3 >> k) & 8'h1) != 0, 1'b0);
      if (o_frm_err) ferr_seen = 1'b1;
    end
    chk("resync_ferr_after", {31'h0, ferr_seen}, 32'h0);
    chk("resync_word", {24'h0, o_word}, 32'hC3);
    chk("resync_vld", {31'h0, o_vld}, 32'h1);
    tick();

    // Overflow: o_rdy low, 0x11 held, 0x22 dropped.
    do_reset();
    o_rdy = 1'b0;
    sb_q.push_back(8'h11);
    send_bits(8'h11, 0, W - 1, 1'b1, 0);
    chk("ovf_first_word", {24'h0, o_word}, 32'h11);
    chk("ovf_first_ovf", {31'h0, o_ovf}, 32'h0);
    send_bits(8'h22, 0, W - 1, 1'b0, 0);
    chk("ovf_word_kept", {24'h0, o_word}, 32'h11);
    chk("ovf_set", {31'h0, o_ovf}, 32'h1);
    chk("ovf_vld_held", {31'h0, o_vld}, 32'h1);
    repeat (3) tick();
    chk("ovf_sticky", {31'h0, o_ovf}, 32'h1);
    o_rdy = 1'b1;
    tick();
    chk("ovf_vld_clr", {31'h0, o_vld}, 32'h0);
    chk("ovf_sticky_after_rdy", {31'h0, o_ovf}, 32'h1);

    // Completion on the accepting edge: 0x11 consumed, 0x33 loads.
    do_reset();
    chk("ovf_cleared_by_rst", {31'h0, o_ovf}, 32'h0);
    o_rdy = 1'b0;
    sb_q.push_back(8'h11);
    sb_q.push_back(8'h33);
    send_bits(8'h11, 0, W - 1, 1'b1, 0);
    send_bits(8'h33, 0, W - 2, 1'b1, 0);
    chk("same_edge_pending", {24'h0, o_word}, 32'h11);
    o_rdy = 1'b1;
    send_bits(8'h33, W - 1, W - 1, 1'b0, 0);
    chk("same_edge_word", {24'h0, o_word}, 32'h33);
    chk("same_edge_vld", {31'h0, o_vld}, 32'h1);
    chk("same_edge_ovf", {31'h0, o_ovf}, 32'h0);
    tick();
    chk("same_edge_vld_clr", {31'h0, o_vld}, 32'h0);

    // Mid-word reset: 5 bits, reset, then 0xFF without sof.
    send_bits(8'h15, 0, 4, 1'b1, 0);
    r = 1'b1;
    i = 1'b1; i_vld = 1'b1; i_sof = 1'b1;
    tick();
    i_vld = 1'b0; i_sof = 1'b0; i = 1'b0;
    chk("rst_mid_word", {24'h0, o_word}, 32'h0);
    chk("rst_mid_vld",  {31'h0, o_vld}, 32'h0);
    chk("rst_mid_ferr", {31'h0, o_frm_err}, 32'h0);
    chk("rst_mid_ovf",  {31'h0, o_ovf}, 32'h0);
    r = 1'b0;
    sb_q.push_back(8'hFF);
    ferr_seen = 1'b0;
    for (int k = 0; k < W; k++) begin
      drive_bit(1'b1, 1'b0);
      if (o_frm_err) ferr_seen = 1'b1;
    end
    chk("post_rst_word", {24'h0, o_word}, 32'hFF);
    chk("post_rst_vld", {31'h0, o_vld}, 32'h1);
    chk("post_rst_ferr", {31'h0, ferr_seen}, 32'h0);
    tick(); tick();

    chk("sb_empty", sb_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
